mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus: address, write strobe, write data and read data, plus the I/O backpressure flag.
- Serves 128KB RAM with one-cycle read latency and the memory-mapped I/O window at mem_a[17:16]==2'b11: UART TX/RX bytes, cycle counter and program-stop.
- Drives io_buffer_full back to the CPU from a TX FIFO occupancy threshold.
- Sits between the cpu top and the UART/host-interface logic.

---
 rtl/mem_io_responder_if.sv | 32 +++
 rtl/mem_io_responder.sv | 146 ++++++++++++++
 tb/tb_mem_io_responder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART TX/RX handshake seen by the memory/IO responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_wr, mem_wdata,
    output tx_ready, rx_data, rx_valid,
    input  mem_rdata, io_buffer_full,
    input  tx_data, tx_valid, rx_ready,
    input  program_stop, tx_overflow
  );

  modport slave (
    input  mem_a, mem_wr, mem_wdata,
    input  tx_ready, rx_data, rx_valid,
    output mem_rdata, io_buffer_full,
    output tx_data, tx_valid, rx_ready,
    output program_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped UART/counter/stop window at 0x3xxxx.
// TX bytes queue in a small FIFO whose fill level throttles the CPU.
module mem_io_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input logic clk_in,
  input logic rst_in,
  mem_io_responder_if.slave bus
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int TH    = TX_DEPTH - FULL_MARGIN;
  localparam logic [PTR_W:0]   FULL_TH = TH[PTR_W:0];
  localparam logic [PTR_W:0]   DEPTH_C = TX_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic [7:0]       r_ram [2**RAM_ADDR_W];
  logic [7:0]       r_fifo [TX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_rdata;
  logic [31:0]      r_cnt;
  logic [31:8]      r_snap;
  logic             r_stop;
  logic             r_ovf;

  logic                  w_io;
  logic [RAM_ADDR_W-1:0] w_idx;
  logic [15:0]           w_off;
  logic                  w_rd;
  logic                  w_rd_ram;
  logic                  w_rd_rx;
  logic                  w_rd_cnt;
  logic                  w_rd_s5;
  logic                  w_rd_s6;
  logic                  w_rd_s7;
  logic                  w_wr_ram;
  logic                  w_wr_tx;
  logic                  w_wr_stop;
  logic                  w_push;
  logic [7:0]            w_push_data;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_accept;
  logic [7:0]            w_rdata_nxt;
  logic                  w_unused_hi;

  assign w_unused_hi = ^bus.mem_a[31:18];

  assign w_io  = (bus.mem_a[17:16] == 2'b11);
  assign w_idx = bus.mem_a[RAM_ADDR_W-1:0];
  assign w_off = bus.mem_a[15:0];
  assign w_rd  = !bus.mem_wr;

  assign w_rd_ram = w_rd && !w_io;
  assign w_rd_rx  = w_rd && w_io && (w_off == 16'h0000);
  assign w_rd_cnt = w_rd && w_io && (w_off == 16'h0004);
  assign w_rd_s5  = w_rd && w_io && (w_off == 16'h0005);
  assign w_rd_s6  = w_rd && w_io && (w_off == 16'h0006);
  assign w_rd_s7  = w_rd && w_io && (w_off == 16'h0007);

  assign w_wr_ram  = bus.mem_wr && !w_io;
  assign w_wr_tx   = bus.mem_wr && w_io
                   && (w_off == 16'h0000)
                   && (bus.mem_wdata != 8'h00);
  assign w_wr_stop = bus.mem_wr && w_io
                   && (w_off == 16'h0004);

  // A stop write doubles as a NUL marker in the TX stream.
  assign w_push      = w_wr_tx || w_wr_stop;
  assign w_push_data = w_wr_stop ? 8'h00 : bus.mem_wdata;

  assign w_pop    = (r_count != '0) && bus.tx_ready;
  assign w_full   = (r_count == DEPTH_C);
  assign w_accept = w_push && (!w_full || w_pop);

  assign bus.tx_valid       = (r_count != '0);
  assign bus.tx_data        = r_fifo[r_rd_ptr];
  assign bus.io_buffer_full = (r_count >= FULL_TH);
  assign bus.rx_ready       = w_rd_rx && bus.rx_valid
                            && !rst_in;
  assign bus.mem_rdata      = r_rdata;
  assign bus.program_stop   = r_stop;
  assign bus.tx_overflow    = r_ovf;

  always_comb begin
    w_rdata_nxt = r_rdata;
    if (w_rd) begin
      unique case (1'b1)
        w_rd_ram: w_rdata_nxt = r_ram[w_idx];
        w_rd_rx:  w_rdata_nxt = bus.rx_valid ?
                                bus.rx_data : 8'h00;
        w_rd_cnt: w_rdata_nxt = r_cnt[7:0];
        w_rd_s5:  w_rdata_nxt = r_snap[15:8];
        w_rd_s6:  w_rdata_nxt = r_snap[23:16];
        w_rd_s7:  w_rdata_nxt = r_snap[31:24];
        default:  w_rdata_nxt = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_wr_ram) r_ram[w_idx] <= bus.mem_wdata;
  end

  always_ff @(posedge clk_in) begin
    if (w_accept) r_fifo[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rdata <= '0;
      r_cnt   <= '0;
      r_snap  <= '0;
    end else begin
      r_rdata <= w_rdata_nxt;
      r_cnt   <= r_cnt + 32'd1;
      // Upper bytes come from this snapshot so a dword read is coherent.
      if (w_rd_cnt) r_snap <= r_cnt[31:8];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stop   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_accept && !w_pop)
        r_count <= r_count + CNT_ONE;
      else if (!w_accept && w_pop)
        r_count <= r_count - CNT_ONE;
      if (w_push && !w_accept) r_ovf <= 1'b1;
      if (w_wr_stop) r_stop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized traffic against a queue/array reference model.
module tb_mem_io_responder;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;

  mem_io_responder_if bus();

  mem_io_responder #(
    .RAM_ADDR_W (17),
    .TX_DEPTH   (DEPTH),
    .FULL_MARGIN(MARGIN)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int n_chk;
  int n_pass;

  logic [7:0]  m_ram [logic [16:0]];
  logic [7:0]  m_q [$];
  logic [7:0]  m_rdata;
  logic [31:0] m_cyc;
  logic [31:0] m_snap;
  logic        m_stop;
  logic        m_ovf;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_rdata = 8'h00;
    m_cyc   = 32'd0;
    m_snap  = 32'd0;
    m_stop  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic [31:0] a,
                     input logic        wr,
                     input logic [7:0]  wd,
                     input logic        txr,
                     input logic        rxv,
                     input logic [7:0]  rxd);
    logic        io;
    logic [15:0] off;
    logic        pop;
    logic        push;
    logic        full_pre;
    logic [7:0]  pd;
    bus.mem_a     = a;
    bus.mem_wr    = wr;
    bus.mem_wdata = wd;
    bus.tx_ready  = txr;
    bus.rx_valid  = rxv;
    bus.rx_data   = rxd;
    io  = (a[17:16] == 2'b11);
    off = a[15:0];
    #4;
    chk("rx_ready", bus.rx_ready,
        !rst_in && !wr && io && off == 0 && rxv);
    chk("tx_valid", bus.tx_valid, m_q.size() != 0);
    if (m_q.size() != 0)
      chk("tx_data", bus.tx_data, m_q[0]);
    chk("io_buffer_full", bus.io_buffer_full,
        m_q.size() >= DEPTH - MARGIN);
    @(posedge clk_in);
    if (!rst_in) begin
      pop      = (m_q.size() != 0) && txr;
      push     = wr && io &&
                 ((off == 0 && wd != 0) || off == 4);
      pd       = (off == 4) ? 8'h00 : wd;
      full_pre = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full_pre || pop) m_q.push_back(pd);
        else m_ovf = 1'b1;
      end
      if (wr && io && off == 4) m_stop = 1'b1;
      if (wr && !io) m_ram[a[16:0]] = wd;
      if (!wr) begin
        if (!io)             m_rdata = m_ram[a[16:0]];
        else if (off == 0)   m_rdata = rxv ? rxd : 8'h00;
        else if (off == 4) begin
          m_rdata = m_cyc[7:0];
          m_snap  = m_cyc;
        end
        else if (off == 5)   m_rdata = m_snap[15:8];
        else if (off == 6)   m_rdata = m_snap[23:16];
        else if (off == 7)   m_rdata = m_snap[31:24];
        else                 m_rdata = 8'h00;
      end
      m_cyc = m_cyc + 32'd1;
    end
    #1;
    chk("mem_rdata", bus.mem_rdata, m_rdata);
    chk("program_stop", bus.program_stop, m_stop);
    chk("tx_overflow", bus.tx_overflow, m_ovf);
  endtask

  task automatic idle(input int n, input logic txr);
    repeat (n) cyc(32'h0003_0010, 1'b0, 8'h00,
                   txr, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [7:0] d,
                    input logic txr);
    cyc(a, 1'b1, d, txr, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  vec_t        tbl [11];
  logic [31:0] ramset [8];
  logic [7:0]  preval [8];

  initial begin
    logic [31:0] dw;
    logic [31:0] a;
    int          k;
    int          pct;
    n_chk  = 0;
    n_pass = 0;

    ramset = '{32'h00000, 32'h00123, 32'h00124, 32'h1FFFF,
               32'h00456, 32'h0ABCD, 32'h10000, 32'h2F00F};
    preval = '{8'h11, 8'h22, 8'h5E, 8'h33,
               8'h44, 8'h55, 8'h66, 8'h77};

    tbl[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 8'h00};
    tbl[1]  = '{32'h0000_0123, 1'b0, 8'h00, 8'hA5};
    tbl[2]  = '{32'h0000_0124, 1'b0, 8'h00, 8'h5E};
    tbl[3]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 8'h5E};
    tbl[4]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h3C};
    tbl[5]  = '{32'hFFFC_0123, 1'b0, 8'h00, 8'hA5};
    tbl[6]  = '{32'h0003_0001, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{32'h0003_0008, 1'b1, 8'h77, 8'h00};
    tbl[8]  = '{32'h0000_0000, 1'b0, 8'h00, 8'h11};
    tbl[9]  = '{32'h0000_0124, 1'b1, 8'hC3, 8'h11};
    tbl[10] = '{32'h0000_0124, 1'b0, 8'h00, 8'hC3};

    bus.mem_a     = 32'h0003_0010;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 8'h00;
    bus.tx_ready  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    rst_in = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    chk("rst_rdata", bus.mem_rdata, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_ibf", bus.io_buffer_full, 0);
    chk("rst_stop", bus.program_stop, 0);
    chk("rst_ovf", bus.tx_overflow, 0);
    m_reset();
    @(posedge clk_in);
    #1;
    idle(2, 1'b0);
    rst_in = 1'b0;

    for (int i = 0; i < 8; i++)
      wr(ramset[i], preval[i], 1'b0);

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].a, tbl[i].wr, tbl[i].wd,
          1'b0, 1'b0, 8'h00);
      chk($sformatf("vec%0d", i), bus.mem_rdata, tbl[i].exp);
    end

    // TX path: NUL write is not a push, no bypass when empty.
    wr(32'h30000, 8'h41, 1'b0);
    wr(32'h30000, 8'h00, 1'b0);
    wr(32'h30000, 8'h42, 1'b0);
    chk("tx_head41", bus.tx_data, 8'h41);
    idle(1, 1'b1);
    chk("tx_head42", bus.tx_data, 8'h42);
    chk("tx_valid42", bus.tx_valid, 1);
    idle(1, 1'b1);
    chk("tx_empty", bus.tx_valid, 0);

    // Backpressure threshold and overflow.
    for (int i = 1; i <= 17; i++) begin
      wr(32'h30000, 8'(i), 1'b0);
      chk($sformatf("ibf_push%0d", i),
          bus.io_buffer_full, i >= 14);
    end
    chk("overflow_set", bus.tx_overflow, 1);
    wr(32'h30000, 8'h99, 1'b1);
    chk("full_pushpop_head", bus.tx_data, 8'h02);
    chk("full_pushpop_ibf", bus.io_buffer_full, 1);
    idle(16, 1'b1);
    chk("drained", bus.tx_valid, 0);

    // RX pop and program stop.
    cyc(32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7A);
    chk("rx_byte", bus.mem_rdata, 8'h7A);
    cyc(32'h30010, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7A);
    cyc(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7A);
    chk("rx_empty", bus.mem_rdata, 8'h00);
    wr(32'h30004, 8'h55, 1'b0);
    chk("stop_set", bus.program_stop, 1);
    chk("stop_nul_valid", bus.tx_valid, 1);
    chk("stop_nul_data", bus.tx_data, 8'h00);
    idle(1, 1'b1);

    // Async reset mid-cycle with 5 bytes queued.
    for (int i = 0; i < 5; i++)
      wr(32'h30000, 8'(8'h10 + i), 1'b0);
    rd(32'h00123);
    chk("pre_rst_rdata", bus.mem_rdata, 8'hA5);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_tx_valid", bus.tx_valid, 0);
    chk("arst_ibf", bus.io_buffer_full, 0);
    chk("arst_stop", bus.program_stop, 0);
    chk("arst_rdata", bus.mem_rdata, 0);
    chk("arst_ovf", bus.tx_overflow, 0);
    m_reset();
    @(posedge clk_in);
    #1;
    idle(2, 1'b0);
    rst_in = 1'b0;

    // Counter: 100 edges after release, then a coherent dword read.
    idle(100, 1'b0);
    dw = '0;
    for (int i = 0; i < 4; i++) begin
      rd(32'h30004 + 32'(i));
      dw[8*i +: 8] = bus.mem_rdata;
    end
    chk("counter_dword", dw, 32'd100);
    rd(32'h00123);
    chk("ram_kept", bus.mem_rdata, 8'hA5);

    // Randomized traffic.
    pct = 20;
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) pct = (pct == 20) ? 85 : 20;
      k = int'($urandom_range(0, 9));
      if (k <= 3) begin
        a = ramset[$urandom_range(0, 7)]
          | ($urandom() & 32'hFFFC_0000);
        cyc(a, 1'($urandom_range(0, 1)), 8'($urandom()),
            $urandom_range(0, 99) >= pct,
            1'($urandom_range(0, 1)), 8'($urandom()));
      end else if (k <= 6) begin
        cyc(32'h30000, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 8'h00
                                       : 8'($urandom()),
            $urandom_range(0, 99) >= pct,
            1'($urandom_range(0, 1)), 8'($urandom()));
      end else if (k == 7) begin
        cyc(32'h30004 + 32'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0, 8'($urandom()),
            $urandom_range(0, 99) >= pct,
            1'($urandom_range(0, 1)), 8'($urandom()));
      end else begin
        cyc(32'h30000 + 32'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 8'($urandom()),
            $urandom_range(0, 99) >= pct,
            1'($urandom_range(0, 1)), 8'($urandom()));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
